mont_adder_sequencer: RTL and testbench
=======================================

// Module: mont_adder_sequencer
// PURPOSE
// - Control FSM for the mpadder carry-save datapath: one start clears the adder, runs ITERATIONS carry-save steps, then resolves the carry-save pair.
// - It then repeats conditional-subtract passes until mpadder reports subtract_finished, and reports done.
// - Sits between the Montgomery top-level/AXI wrapper and mpadder; it drives c_doubleshift, subtract and the phase bus (showFluffyPonies).
// PARAMETERS
// - ITERATIONS  128  number of c_doubleshift cycles per multiplication (512 bits / 4 bits per step)
// - MAX_PASSES  4    subtract passes allowed before error is raised
// - A_WIDTH     512  width of multiplier operand A
// PORTS
// - clk           in   1        clock
// - resetn        in   1        asynchronous active-low reset
// - start         in   1        begin operation; sampled only in IDLE
// - a_in          in   A_WIDTH  operand A; latched on the accepted start
// - subtract_fin  in   1        mpadder subtract_finished
// - adder_resetn  out  1        synchronous clear to mpadder resetn; low for exactly 1 cycle (CLEAR)
// - c_doubleshift out  1        mpadder carry-save step enable
// - subtract      out  1        mpadder subtract mode
// - phase         out  4        mpadder showFluffyPonies; 4'b1000 = hold
// - a_digit       out  4        low nibble of A shift register (multiple select for B0..B3)
// - busy          out  1        high from accepted start until done
// - done          out  1        1-cycle pulse; mpadder trueResult valid from this cycle until the next start
// - error         out  1        sticky; set on pass overflow, cleared by the next accepted start
// - passes        out  3        number of subtract passes used by the last operation
// BEHAVIOUR
// - Reset values: adder_resetn=1, c_doubleshift=0, subtract=0, phase=4'b1000, a_digit=0, busy=0, done=0, error=0, passes=0; state=IDLE.
// - All outputs are registered; the async reset may assert in any state and returns to IDLE with the values above. mpadder state is not guaranteed afterwards.
// - IDLE: phase=4'b1000. start=1 -> CLEAR: latch a_in, clear iteration count, pass count and error, set busy=1.
// - start is ignored while busy=1 (no queueing).
// - CLEAR (1 cycle): adder_resetn=0 -> MULT.
// - MULT (ITERATIONS cycles): c_doubleshift=1, phase=4'd0, subtract=0.
//   - a_digit=A[3:0] on each cycle; A shifts right 4 bits each cycle.
//   - The iteration counter counts 0..ITERATIONS-1; at the last count -> RES.
// - RES (6 cycles): c_doubleshift=0, subtract=0, phase steps 0,1,2,3,4,5 (one cycle each) -> SUB with phase=0.
// - SUB pass (6 cycles): subtract=1, phase steps 0..5.
//   - phase=0 of each pass increments passes; mpadder commits the previous result into c_regb on this cycle.
//   - At phase=5: if subtract_fin=1 -> DONE.
//   - Otherwise, if passes==MAX_PASSES -> DONE with error=1.
//   - Otherwise start the next pass at phase=0.
//   - subtract_fin is sampled only at phase 5 of SUB; it is ignored in all other cycles.
// - DONE (1 cycle): done=1, busy=0, subtract=0, phase=4'b1000 -> IDLE.
//   - Entry to IDLE freezes the mpadder pipeline; trueResult stays stable.
// - Latency, no error: 1 + ITERATIONS + 6 + 6*passes + 1 cycles from accepted start to done.
//   - ITERATIONS=128, passes=1: 142 cycles.
// - phase is never 6 or 7; bit3 is set only in IDLE and DONE.
// - c_doubleshift and subtract are never high in the same cycle.
// - Iteration count wrap: the counter is ITERATIONS-exact and does not wrap into a 129th step.
// - start in the same cycle as done: ignored, because DONE is not IDLE; the start is accepted on the next cycle if still high.
// TESTING
// - Reset mid-MULT (cycle 50): resetn=0 -> all outputs at reset values within 0 clocks (async); the next start runs a full 142-cycle op.
// - A=512'h1, B=1, M odd with a single subtract pass -> done at cycle 142; a_digit=1 on the first MULT cycle then 0; passes=1, error=0.
// - subtract_fin held low throughout -> 4 passes, done at cycle 160 with error=1; error clears on the next start.
// - subtract_fin pulsed at phase 3 of pass 1 and high at phase 5 of pass 2 -> passes=2, done at cycle 148.
// - start held high continuously -> ops back-to-back with one IDLE cycle between done and the next CLEAR; the second start is not accepted during busy.
// - Per-cycle checker for the whole run:
//   - phase sequence per op is 0 x128, 0..5, (0..5) x passes;
//   - adder_resetn is low exactly once per op;
//   - c_doubleshift and subtract are never high together.

Source files
------------

// File: rtl/mont_adder_sequencer.sv
// mont_adder_sequencer
// Control FSM for the mpadder carry-save datapath. An accepted start clears
// the adder, runs ITERATIONS carry-save steps, resolves the carry-save pair,
// then repeats conditional-subtract passes until mpadder reports
// subtract_finished (or MAX_PASSES is reached) and pulses done.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            begin operation (sampled only in IDLE)
//   a_in             operand A, latched on the accepted start
//   subtract_fin     mpadder subtract_finished, sampled at phase 5 of SUB
//   adder_resetn     mpadder clear, low for the single CLEAR cycle
//   c_doubleshift    mpadder carry-save step enable
//   subtract         mpadder subtract mode
//   phase            mpadder showFluffyPonies (4'b1000 = hold)
//   a_digit          current 4-bit digit of A
//   busy, done       operation in progress / 1-cycle completion pulse
//   error            sticky pass-overflow flag, cleared on accepted start
//   passes           subtract passes used by the last operation
module mont_adder_sequencer #(
  parameter int unsigned ITERATIONS = 128,
  parameter int unsigned MAX_PASSES = 4,
  parameter int unsigned A_WIDTH    = 512
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [A_WIDTH-1:0] a_in,
  input  logic               subtract_fin,
  output logic               adder_resetn,
  output logic               c_doubleshift,
  output logic               subtract,
  output logic [3:0]         phase,
  output logic [3:0]         a_digit,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         passes
);

  localparam int unsigned    CW   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ITERATIONS - 1);
  localparam logic [2:0]     PMAX = 3'(MAX_PASSES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MULT, S_RES, S_SUB, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      iter, iter_n;
  logic [2:0]         step, step_n;
  logic [2:0]         pass_cnt, pass_n;
  logic [A_WIDTH-1:0] a_sh, a_sh_n;
  logic               err, err_n;

  logic               adder_resetn_n, c_doubleshift_n, subtract_n, busy_n, done_n;
  logic [3:0]         phase_n, a_digit_n;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      iter          <= '0;
      step          <= '0;
      pass_cnt      <= '0;
      a_sh          <= '0;
      err           <= 1'b0;
      adder_resetn  <= 1'b1;
      c_doubleshift <= 1'b0;
      subtract      <= 1'b0;
      phase         <= 4'b1000;
      a_digit       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      iter          <= iter_n;
      step          <= step_n;
      pass_cnt      <= pass_n;
      a_sh          <= a_sh_n;
      err           <= err_n;
      adder_resetn  <= adder_resetn_n;
      c_doubleshift <= c_doubleshift_n;
      subtract      <= subtract_n;
      phase         <= phase_n;
      a_digit       <= a_digit_n;
      busy          <= busy_n;
      done          <= done_n;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n = state;
    iter_n  = iter;
    step_n  = step;
    pass_n  = pass_cnt;
    a_sh_n  = a_sh;
    err_n   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          a_sh_n  = a_in;
          iter_n  = '0;
          pass_n  = '0;
          err_n   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_n = S_MULT;
        iter_n  = '0;
      end
      S_MULT: begin
        if (iter == LAST) begin
          state_n = S_RES;
          step_n  = '0;
        end else begin
          iter_n = iter + CW'(1);
        end
      end
      S_RES: begin
        if (step == 3'd5) begin
          state_n = S_SUB;
          step_n  = '0;
          pass_n  = pass_cnt + 3'd1;
        end else begin
          step_n = step + 3'd1;
        end
      end
      S_SUB: begin
        if (step == 3'd5) begin
          if (subtract_fin) begin
            state_n = S_DONE;
          end else if (pass_cnt == PMAX) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            step_n = '0;
            pass_n = pass_cnt + 3'd1;
          end
        end else begin
          step_n = step + 3'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // The digit presented in a MULT cycle is taken from the register one
    // cycle earlier, so A shifts whenever the next cycle is a MULT cycle.
    if (state_n == S_MULT) a_sh_n = a_sh >> 4;
  end

  // Outputs are decoded from the next state so they can be registered
  always_comb begin
    adder_resetn_n  = (state_n != S_CLEAR);
    c_doubleshift_n = (state_n == S_MULT);
    subtract_n      = (state_n == S_SUB);
    busy_n          = (state_n == S_CLEAR) || (state_n == S_MULT) ||
                      (state_n == S_RES)   || (state_n == S_SUB);
    done_n          = (state_n == S_DONE);
    a_digit_n       = (state_n == S_MULT) ? a_sh[3:0] : '0;
    case (state_n)
      S_RES, S_SUB:   phase_n = {1'b0, step_n};
      S_CLEAR, S_MULT: phase_n = 4'd0;
      default:        phase_n = 4'b1000;
    endcase
  end

  assign error  = err;
  assign passes = pass_cnt;

endmodule

// File: tb/tb_mont_adder_sequencer.sv
module tb_mont_adder_sequencer;

  localparam int AW = 512;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] a_in;
  logic          subtract_fin = 1'b0;
  logic          adder_resetn, c_doubleshift, subtract, busy, done, error;
  logic [3:0]    phase, a_digit;
  logic [2:0]    passes;

  always #5 clk = ~clk;

  mont_adder_sequencer #(
    .ITERATIONS(128),
    .MAX_PASSES(4),
    .A_WIDTH(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .a_in(a_in),
    .subtract_fin(subtract_fin), .adder_resetn(adder_resetn),
    .c_doubleshift(c_doubleshift), .subtract(subtract), .phase(phase),
    .a_digit(a_digit), .busy(busy), .done(done), .error(error), .passes(passes)
  );

  // mode 0: subtract_fin always high; 1: always low; 2: pulse at pass-1 phase 3
  // and high at pass-2 phase 5
  typedef struct {
    logic [AW-1:0] a;
    int            lat;
    logic [2:0]    npass;
    logic          err;
    int            mode;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  logic [AW-1:0] a_model;
  int            checks = 0;
  int            errors = 0;
  int            k = 0;      // cycle index within the current op, 0 = idle
  int            dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic fin_drive(input int mode, input int kk);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return (kk == 139) || (kk == 147);
    endcase
  endfunction

  // {adder_resetn, c_doubleshift, subtract, phase, busy, done}
  function automatic logic [8:0] exp_vec(input int kk, input int lat);
    if (kk == 0)        return {1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    if (kk == 1)        return {1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    if (kk <= 129)      return {1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    if (kk <= 135)      return {1'b1, 1'b0, 1'b0, 4'(kk - 130), 1'b1, 1'b0};
    if (kk < lat)       return {1'b1, 1'b0, 1'b1, 4'((kk - 136) % 6), 1'b1, 1'b0};
    return {1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
  endfunction

  // Monitor: per-cycle output check, pops the scoreboard at the end of each op
  always @(negedge clk) begin
    if (!resetn) begin
      if (k != 0) begin
        void'(q.pop_front());
        k = 0;
      end
      subtract_fin = 1'b0;
    end else if (k == 0) begin
      subtract_fin = 1'b0;
      check("idle_outputs", {adder_resetn, c_doubleshift, subtract, phase, busy, done},
            exp_vec(0, 0));
      if (start) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected: got start accepted expected no pending op");
        end else begin
          cur     = q[0];
          a_model = cur.a;
          k       = 1;
        end
      end
    end else begin
      subtract_fin = fin_drive(cur.mode, k);
      check($sformatf("cycle_%0d", k),
            {adder_resetn, c_doubleshift, subtract, phase, busy, done}, exp_vec(k, cur.lat));
      if (k == 1) check("cleared_on_start", {error, passes}, 4'b0);
      if (k >= 2 && k <= 129) begin
        check($sformatf("a_digit_%0d", k), a_digit, a_model[3:0]);
        a_model = a_model >> 4;
      end
      if (done || k == cur.lat) begin
        void'(q.pop_front());
        dones++;
        check("done_latency", k, cur.lat);
        check("passes", passes, cur.npass);
        check("error", error, cur.err);
        k = 0;
      end else if (k >= 300) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done by cycle %0d expected %0d", k, cur.lat);
        void'(q.pop_front());
        k = 0;
      end else begin
        k++;
      end
    end
  end

  task automatic check_reset_values();
    check("reset_values",
          {adder_resetn, c_doubleshift, subtract, phase, a_digit, busy, done, error, passes},
          {1'b1, 1'b0, 1'b0, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b0, 3'b0});
  endtask

  task automatic push(input logic [AW-1:0] a, input int mode, input int lat,
                      input logic [2:0] np, input logic e);
    exp_t x;
    x.a = a; x.mode = mode; x.lat = lat; x.npass = np; x.err = e;
    q.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (k != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (k != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy at cycle %0d expected idle", k);
    end
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (dones < target && n < 800) begin
      @(posedge clk); #1;
      n++;
    end
    if (dones < target) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got %0d dones expected %0d", dones, target);
    end
  endtask

  task automatic run_op(input logic [AW-1:0] a, input int mode, input int lat,
                        input logic [2:0] np, input logic e);
    int base;
    push(a, mode, lat, np, e);
    wait_idle();
    base  = dones;
    a_in  = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_dones(base + 1);
  endtask

  initial begin
    int n;
    int base;
    logic [AW-1:0] pat;
    resetn = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    #12;
    check_reset_values();
    @(posedge clk); #1;
    resetn = 1'b1;

    pat = '0;
    pat[63:0] = 64'hFEDC_BA98_7654_3210;

    run_op(512'h1, 0, 142, 3'd1, 1'b0);
    run_op(pat,    1, 160, 3'd4, 1'b1);
    run_op(512'h0, 0, 142, 3'd1, 1'b0);
    run_op({128{4'hA}}, 2, 148, 3'd2, 1'b0);

    // asynchronous reset in the middle of MULT
    push(pat, 0, 142, 3'd1, 1'b0);
    wait_idle();
    a_in  = pat;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (k != 50 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_cycle_50", k, 50);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op(512'h1, 0, 142, 3'd1, 1'b0);

    // start held high: back-to-back ops separated by one idle cycle
    push(512'h5, 0, 142, 3'd1, 1'b0);
    push(512'h5, 2, 148, 3'd2, 1'b0);
    wait_idle();
    base  = dones;
    a_in  = 512'h5;
    start = 1'b1;
    wait_dones(base + 2);
    start = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
